uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 143 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: one-shot capture of each rx_done into a FWFT frame FIFO, ack handshake, error flags, irq.
// Write lands 2 edges after rx_done rises; a full FIFO drops the frame (overrun) unless a pop frees the slot that cycle.
module uart_rx_ctrl #(
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_i,
   input  logic          rx_done_i,
   input  logic [7:0]    rx_data_i,
   input  logic          parity_error_i,
   output logic          rx_ack_o,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic          clr_err_i,
   input  logic [LW-1:0] irq_thresh_i,
   output logic [7:0]    fifo_data_o,
   output logic          fifo_perr_o,
   output logic          fifo_empty_o,
   output logic          fifo_full_o,
   output logic [LW-1:0] fifo_level_o,
   output logic          overrun_o,
   output logic [7:0]    perr_cnt_o,
   output logic          irq_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_ACK     = 2'd2;

   localparam logic [PW-1:0] PTR_ONE = 1;
   localparam logic [LW-1:0] LVL_ONE = 1;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [8:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic [LW-1:0] w_level_nxt;
   logic [LW-1:0] w_thresh;
   logic          r_overrun;
   logic          w_overrun_nxt;
   logic [7:0]    r_perr_cnt;
   logic          r_irq;

   logic w_full;
   logic w_empty;
   logic w_cap;
   logic w_pop;
   logic w_wr;
   logic w_drop;

   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_cap   = (r_state == S_CAPTURE);

   // Flush wins over both ports; a coincident pop lets a capture into a full FIFO succeed.
   assign w_pop  = pop_i & ~w_empty & ~flush_i;
   assign w_wr   = w_cap & (~w_full | w_pop) & ~flush_i;
   assign w_drop = w_cap & w_full & ~w_pop & ~flush_i;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (en_i && rx_done_i) w_state_nxt = S_CAPTURE;
         S_CAPTURE: w_state_nxt = S_ACK;
         S_ACK:     if (!rx_done_i) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_level_nxt = r_level;
      if (flush_i)
         w_level_nxt = '0;
      else if (w_wr && !w_pop)
         w_level_nxt = r_level + LVL_ONE;
      else if (!w_wr && w_pop)
         w_level_nxt = r_level - LVL_ONE;
   end

   always_comb begin
      w_overrun_nxt = r_overrun;
      if (w_drop)
         w_overrun_nxt = 1'b1;
      else if (flush_i || clr_err_i)
         w_overrun_nxt = 1'b0;
   end

   assign w_thresh = (irq_thresh_i == '0) ? LVL_ONE : irq_thresh_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overrun  <= 1'b0;
         r_perr_cnt <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_level   <= w_level_nxt;
         r_overrun <= w_overrun_nxt;
         r_irq     <= en_i & ((w_level_nxt >= w_thresh) | w_overrun_nxt);
         if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         // A parity event in the clearing cycle restarts the count at one.
         if (w_wr && parity_error_i) begin
            if (clr_err_i)
               r_perr_cnt <= 8'd1;
            else if (r_perr_cnt != 8'hFF)
               r_perr_cnt <= r_perr_cnt + 8'd1;
         end else if (clr_err_i) begin
            r_perr_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= {parity_error_i, rx_data_i};
   end

   assign rx_ack_o     = (r_state == S_ACK);
   assign fifo_data_o  = r_mem[r_rd_ptr][7:0];
   assign fifo_perr_o  = r_mem[r_rd_ptr][8];
   assign fifo_empty_o = w_empty;
   assign fifo_full_o  = w_full;
   assign fifo_level_o = r_level;
   assign overrun_o    = r_overrun;
   assign perr_cnt_o   = r_perr_cnt;
   assign irq_o        = r_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based frame model checked every cycle, plus literal checks of key scenarios.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 4;
   localparam int LW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          en_i;
   logic          rx_done_i;
   logic [7:0]    rx_data_i;
   logic          parity_error_i;
   logic          rx_ack_o;
   logic          pop_i;
   logic          flush_i;
   logic          clr_err_i;
   logic [LW-1:0] irq_thresh_i;
   logic [7:0]    fifo_data_o;
   logic          fifo_perr_o;
   logic          fifo_empty_o;
   logic          fifo_full_o;
   logic [LW-1:0] fifo_level_o;
   logic          overrun_o;
   logic [7:0]    perr_cnt_o;
   logic          irq_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0] q[$];
   bit         m_ovr  = 1'b0;
   int         m_perr = 0;
   bit         m_irq  = 1'b0;
   bit         cap_vld = 1'b0;

   uart_rx_ctrl #(.DEPTH(DEPTH), .LW(LW)) dut (
      .clk(clk), .rst(rst), .en_i(en_i), .rx_done_i(rx_done_i), .rx_data_i(rx_data_i),
      .parity_error_i(parity_error_i), .rx_ack_o(rx_ack_o), .pop_i(pop_i), .flush_i(flush_i),
      .clr_err_i(clr_err_i), .irq_thresh_i(irq_thresh_i), .fifo_data_o(fifo_data_o),
      .fifo_perr_o(fifo_perr_o), .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o),
      .fifo_level_o(fifo_level_o), .overrun_o(overrun_o), .perr_cnt_o(perr_cnt_o), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the FIFO is a queue, updated on each edge from the bench-driven inputs.
   initial forever begin
      bit stored;
      bit drop;
      int th;
      @(posedge clk or posedge rst);
      if (rst) begin
         q.delete();
         m_ovr  = 1'b0;
         m_perr = 0;
         m_irq  = 1'b0;
      end else begin
         stored = 1'b0;
         drop   = 1'b0;
         if (flush_i) begin
            q.delete();
         end else begin
            if (pop_i && q.size() > 0) void'(q.pop_front());
            if (cap_vld) begin
               if (q.size() < DEPTH) begin
                  q.push_back({parity_error_i, rx_data_i});
                  stored = parity_error_i;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         if (drop) m_ovr = 1'b1;
         else if (flush_i || clr_err_i) m_ovr = 1'b0;
         if (stored) m_perr = clr_err_i ? 1 : ((m_perr < 255) ? m_perr + 1 : 255);
         else if (clr_err_i) m_perr = 0;
         th = (irq_thresh_i == 0) ? 1 : int'(irq_thresh_i);
         m_irq = en_i && ((q.size() >= th) || m_ovr);
      end
   end

   initial forever begin
      @(negedge clk);
      chk("level", int'(fifo_level_o), q.size());
      chk("empty", int'(fifo_empty_o), int'(q.size() == 0));
      chk("full", int'(fifo_full_o), int'(q.size() == DEPTH));
      chk("overrun", int'(overrun_o), int'(m_ovr));
      chk("perr_cnt", int'(perr_cnt_o), m_perr);
      chk("irq", int'(irq_o), int'(m_irq));
      if (q.size() > 0) begin
         chk("head_data", int'(fifo_data_o), int'(q[0][7:0]));
         chk("head_perr", int'(fifo_perr_o), int'(q[0][8]));
      end
   end

   task automatic start_frame(input logic [7:0] d, input logic p);
      @(posedge clk); #1;
      rx_data_i      = d;
      parity_error_i = p;
      rx_done_i      = 1'b1;
   endtask

   // Entered just after the edge where rx_done went (or stayed) high with the FSM idle.
   task automatic finish_frame(input bit pop_cap);
      @(posedge clk); #1;
      cap_vld = 1'b1;
      pop_i   = pop_cap;
      @(posedge clk); #1;
      cap_vld = 1'b0;
      pop_i   = 1'b0;
      @(negedge clk); chk("ack_cycle1", int'(rx_ack_o), 1);
      @(posedge clk); #1;
      rx_done_i = 1'b0;
      @(negedge clk); chk("ack_cycle2", int'(rx_ack_o), 1);
      @(negedge clk); chk("ack_release", int'(rx_ack_o), 0);
   endtask

   task automatic frame(input logic [7:0] d, input logic p, input bit pop_cap);
      start_frame(d, p);
      finish_frame(pop_cap);
   endtask

   task automatic pulse(input int which);
      @(posedge clk); #1;
      if (which == 0) pop_i = 1'b1;
      else if (which == 1) flush_i = 1'b1;
      else clr_err_i = 1'b1;
      @(posedge clk); #1;
      pop_i = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; en_i = 1'b1; rx_done_i = 1'b0; rx_data_i = '0; parity_error_i = 1'b0;
      pop_i = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0; irq_thresh_i = 3'd1;
      repeat (3) @(negedge clk);
      chk("rst_empty", int'(fifo_empty_o), 1);
      chk("rst_level", int'(fifo_level_o), 0);
      chk("rst_ack", int'(rx_ack_o), 0);
      chk("rst_irq", int'(irq_o), 0);
      @(posedge clk); #1; rst = 1'b0;

      frame(8'h5A, 1'b0, 1'b0);
      chk("5a_data", int'(fifo_data_o), 8'h5A);
      chk("5a_level", int'(fifo_level_o), 1);
      repeat (2) @(negedge clk);
      chk("5a_once", int'(fifo_level_o), 1);
      pulse(0);
      chk("5a_popped", int'(fifo_empty_o), 1);

      for (int i = 1; i <= 5; i++) frame(8'(i), 1'b0, 1'b0);
      chk("ovf_level", int'(fifo_level_o), 4);
      chk("ovf_full", int'(fifo_full_o), 1);
      chk("ovf_flag", int'(overrun_o), 1);
      chk("ovf_head", int'(fifo_data_o), 8'h01);
      chk("ovf_irq", int'(irq_o), 1);

      pulse(2);
      chk("clr_ovr", int'(overrun_o), 0);
      frame(8'h66, 1'b0, 1'b1);
      chk("popwr_level", int'(fifo_level_o), 4);
      chk("popwr_ovr", int'(overrun_o), 0);
      chk("popwr_head", int'(fifo_data_o), 8'h02);
      repeat (3) pulse(0);
      chk("popwr_tail", int'(fifo_data_o), 8'h66);
      pulse(1);
      chk("flush_empty", int'(fifo_empty_o), 1);

      frame(8'h33, 1'b1, 1'b0);
      chk("perr_head", int'(fifo_perr_o), 1);
      chk("perr_cnt1", int'(perr_cnt_o), 1);
      for (int i = 0; i < 299; i++) frame(8'(i), 1'b1, 1'b1);
      chk("perr_sat", int'(perr_cnt_o), 255);
      pulse(1);

      irq_thresh_i = 3'd2;
      frame(8'hA1, 1'b0, 1'b0);
      chk("thr2_one", int'(irq_o), 0);
      frame(8'hA2, 1'b0, 1'b0);
      chk("thr2_two", int'(irq_o), 1);
      pulse(0);
      chk("thr2_pop", int'(irq_o), 0);
      @(posedge clk); #1; irq_thresh_i = 3'd0;
      @(negedge clk); @(negedge clk);
      chk("thr0_as1", int'(irq_o), 1);

      @(posedge clk); #1; en_i = 1'b0; rx_done_i = 1'b1; rx_data_i = 8'hEE;
      repeat (3) begin
         @(negedge clk); chk("dis_noack", int'(rx_ack_o), 0);
      end
      chk("dis_level", int'(fifo_level_o), 1);
      @(posedge clk); #1; rx_done_i = 1'b0; en_i = 1'b1;

      start_frame(8'h77, 1'b0);
      @(posedge clk); #1; cap_vld = 1'b1;
      @(posedge clk); #1; cap_vld = 1'b0;
      @(negedge clk); chk("pre_rst_ack", int'(rx_ack_o), 1);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ack", int'(rx_ack_o), 0);
      chk("mid_rst_level", int'(fifo_level_o), 0);
      chk("mid_rst_empty", int'(fifo_empty_o), 1);
      chk("mid_rst_irq", int'(irq_o), 0);
      @(posedge clk); #1; rst = 1'b0;
      finish_frame(1'b0);
      chk("recap_level", int'(fifo_level_o), 1);
      chk("recap_data", int'(fifo_data_o), 8'h77);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
